nonrestoring_div: RTL and testbench

Sequential W-bit integer divider: the inverse of the team's Booth multiplier, computing quotient and remainder of a dividend/divisor pair with one non-restoring add/subtract step per clock. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. The block sits beside the multiplier in the arithmetic datapath.

---
 rtl/div_pkg.sv | 8 +
 rtl/div_step.sv | 18 +
 rtl/nonrestoring_div.sv | 151 +++++++++++++++
 tb/tb_nonrestoring_div.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM states, counter sizing and result constants for the non-restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  localparam logic [63:0] DZ_QUOT = '1;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational non-restoring iteration on partial remainder p and quotient register a
module div_step import div_pkg::*; #(
  parameter int W = 8
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] a,
  input  logic [W-1:0] d,
  output logic [W:0]   p_nx,
  output logic [W-1:0] a_nx
);
  logic [W:0] ps;
  // Dropping p's top bit is safe: the true result always fits back in W+1 bits
  always_comb begin
    ps   = {p[W-1:0], a[W-1]};
    p_nx = p[W] ? ps + {1'b0, d} : ps - {1'b0, d};
    a_nx = {a[W-2:0], ~p_nx[W]};
  end
endmodule

// File: rtl/nonrestoring_div.sv
// nonrestoring_div: sequential W-bit divider, one add/subtract per clock, valid/ready in and out.
// Define NONRESTORING_DIV_SIGNED_EN for two's-complement operands; otherwise unsigned with ovf tied low.
module nonrestoring_div import div_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz,
  output logic         ovf
);
  localparam int CW = cnt_w(W);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    p_q, p_d, p_nx;
  logic [W-1:0]  a_q, a_d, a_nx, d_q, d_d, q_q, q_d, r_q, r_d;
  logic [W-1:0]  dvd_mag, dvs_mag, r_fix;
  logic          dz_q, dz_d, ovf_q, ovf_d, acc, is_ovf, last;
`ifdef NONRESTORING_DIV_SIGNED_EN
  logic          nq_q, nq_d, nr_q, nr_d;
`endif

  div_step #(.W(W)) u_step (.p(p_q), .a(a_q), .d(d_q), .p_nx(p_nx), .a_nx(a_nx));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0 || is_ovf) ? DONE : CALC;
      CALC: if (last) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_comb begin
    acc  = in_valid && state_q == IDLE;
    last = cnt_q == CW'(W - 1);
`ifdef NONRESTORING_DIV_SIGNED_EN
    dvd_mag = dividend[W-1] ? -dividend : dividend;
    dvs_mag = divisor[W-1] ? -divisor : divisor;
    is_ovf  = dividend == {1'b1, {(W-1){1'b0}}} && &divisor;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    is_ovf  = 1'b0;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    a_d   = a_q;
    d_d   = d_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    ovf_d = ovf_q;
`ifdef NONRESTORING_DIV_SIGNED_EN
    nq_d  = nq_q;
    nr_d  = nr_q;
`endif
    r_fix = p_q[W] ? p_q[W-1:0] + d_q : p_q[W-1:0];
    if (acc) begin
      cnt_d = '0;
      p_d   = '0;
      a_d   = dvd_mag;
      d_d   = dvs_mag;
`ifdef NONRESTORING_DIV_SIGNED_EN
      nq_d  = dividend[W-1] ^ divisor[W-1];
      nr_d  = dividend[W-1];
`endif
      if (divisor == '0) begin
        q_d   = DZ_QUOT[W-1:0];
        r_d   = dividend;
        dz_d  = 1'b1;
        ovf_d = 1'b0;
      end else if (is_ovf) begin
        q_d   = {1'b1, {(W-1){1'b0}}};
        r_d   = '0;
        dz_d  = 1'b0;
        ovf_d = 1'b1;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      p_d   = p_nx;
      a_d   = a_nx;
    end else if (state_q == FIX) begin
`ifdef NONRESTORING_DIV_SIGNED_EN
      q_d   = nq_q ? -a_q : a_q;
      r_d   = nr_q ? -r_fix : r_fix;
`else
      q_d   = a_q;
      r_d   = r_fix;
`endif
      dz_d  = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      p_q   <= '0;
      a_q   <= '0;
      d_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
`ifdef NONRESTORING_DIV_SIGNED_EN
      nq_q  <= 1'b0;
      nr_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      a_q   <= a_d;
      d_q   <= d_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
      ovf_q <= ovf_d;
`ifdef NONRESTORING_DIV_SIGNED_EN
      nq_q  <= nq_d;
      nr_q  <= nr_d;
`endif
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nonrestoring_div.sv
// tb_nonrestoring_div: random and directed divisions against an arithmetic reference model
module tb_nonrestoring_div;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dz;
  logic       ovf;
  int         n_chk = 0;
  int         n_fail = 0;

  nonrestoring_div #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                       output logic [7:0] r, output logic edz, output logic eov, output int lat);
    edz = 1'b0;
    eov = 1'b0;
    lat = 10;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      edz = 1'b1;
      lat = 1;
    end else begin
`ifdef NONRESTORING_DIV_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
        eov = 1'b1;
        lat = 1;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
`else
      q = 8'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
`endif
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         lat, cyc;
    model(a, b, eq, er, edz, eov, lat);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quot", 32'(quotient), 32'(eq));
      @(posedge clk);
      #1;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("dz", 32'(dz), 32'(edz));
    chk("ovf", 32'(ovf), 32'(eov));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_quot", 32'(quotient), 32'(eq));
    chk("post_rem", 32'(remainder), 32'(er));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    run(8'd100, 8'd7, 0);
    run(8'(-100), 8'd7, 0);
    run(8'd100, 8'(-7), 0);
    run(8'(-100), 8'(-7), 0);
    run(8'd55, 8'd0, 0);
    run(8'h80, 8'hFF, 0);
    run(8'd200, 8'd9, 0);
    run(8'd128, 8'd255, 0);
    run(8'd127, 8'd1, 0);
    run(8'h80, 8'd1, 0);
    run(8'd37, 8'd100, 20);
    run(8'd9, 8'd3, 0);
    // Abort a division partway and confirm nothing from it survives
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_quot", 32'(quotient), 32'd0);
    chk("midrst_rem", 32'(remainder), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run(8'd9, 8'd3, 0);
    for (int i = 0; i < 40; i++)
      run(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom), int'($urandom_range(0, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
